// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters: one-cycle predict port, RUN-only update port,
// post-reset init walk. Define BHT_BYPASS_EN to forward same-edge updates into predictions.
module bht_sat_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned CTR_INIT   = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_busy,
    input  logic                pred_req,
    input  logic [31:0]         pred_pc,
    output logic                pred_resp_valid,
    output logic                pred_taken,
    output logic [CTR_BITS-1:0] pred_ctr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);
    localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0]   CTR_RST  = CTR_BITS'(CTR_INIT);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [INDEX_BITS-1:0]   init_idx;
    logic [INDEX_BITS-1:0]   init_idx_d;
    logic                    init_busy_d;

    logic [CTR_BITS-1:0]     mem [ENTRIES];

    logic [INDEX_BITS-1:0]   pred_idx;
    logic [INDEX_BITS-1:0]   upd_idx;
    logic [CTR_BITS-1:0]     upd_cur_c;
    logic [CTR_BITS-1:0]     upd_next_c;
    logic [CTR_BITS-1:0]     rd_val_c;

    logic                    wr_en_c;
    logic [INDEX_BITS-1:0]   wr_idx_c;
    logic [CTR_BITS-1:0]     wr_data_c;

    // PC bits outside the index field carry no information for an untagged table
    logic                    unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                              upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    assign pred_idx = pred_pc[INDEX_BITS+1:2];
    assign upd_idx  = upd_pc[INDEX_BITS+1:2];

    // Saturating increment/decrement of the addressed counter
    always_comb begin
        upd_cur_c  = mem[upd_idx];
        upd_next_c = upd_cur_c;
        if (upd_taken) begin
            if (upd_cur_c != CTR_MAX) begin
                upd_next_c = upd_cur_c + CTR_BITS'(1);
            end
        end else begin
            if (upd_cur_c != '0) begin
                upd_next_c = upd_cur_c - CTR_BITS'(1);
            end
        end
    end

    // Next state, init walk progress and the single array write port
    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx;
        init_busy_d = init_busy;
        wr_en_c     = 1'b0;
        wr_idx_c    = '0;
        wr_data_c   = '0;
        case (state_q)
            ST_INIT: begin
                wr_en_c     = 1'b1;
                wr_idx_c    = init_idx;
                wr_data_c   = CTR_RST;
                init_idx_d  = init_idx + INDEX_BITS'(1);
                init_busy_d = 1'b1;
                if (init_idx == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                init_busy_d = 1'b0;
                if (upd_valid) begin
                    wr_en_c   = 1'b1;
                    wr_idx_c  = upd_idx;
                    wr_data_c = upd_next_c;
                end
            end
            default: begin
                state_d     = ST_INIT;
                init_idx_d  = '0;
                init_busy_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            init_idx  <= '0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            init_idx  <= init_idx_d;
            init_busy <= init_busy_d;
        end
    end

    // Array contents survive reset; the walk rewrites them
    always_ff @(posedge clk) begin
        if (!reset && wr_en_c) begin
            mem[wr_idx_c] <= wr_data_c;
        end
    end

    // Prediction read value: zero while walking, otherwise the stored (or forwarded) counter
    always_comb begin
        rd_val_c = mem[pred_idx];
`ifdef BHT_BYPASS_EN
        if (state_q == ST_RUN && upd_valid && (upd_idx == pred_idx)) begin
            rd_val_c = upd_next_c;
        end
`endif
        if (state_q == ST_INIT) begin
            rd_val_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
            pred_ctr        <= '0;
        end else begin
            pred_resp_valid <= pred_req;
            if (pred_req) begin
                pred_ctr   <= rd_val_c;
                pred_taken <= rd_val_c[CTR_BITS-1];
            end
        end
    end

endmodule
